cond_wait_unit: RTL and testbench

- Synthesizable multi-channel "wait until condition" engine for the dynamic-scheduler test fabric.
- Each channel is armed with a comparison against one shared watched value. The channel fires when the condition holds and stays fired until acknowledged.
- Generalises level-sensitive wait(expr) to NUM_CH concurrent waiters with selectable operators and exclusive ranges.
- Sits between a scheduler/sequencer (arm, cancel, ack) and the datapath value being monitored.

---
 rtl/cond_wait_pkg.sv | 24 ++
 rtl/cond_wait_chan.sv | 190 +++++++++++++++++++
 rtl/cond_wait_unit.sv | 79 +++++++
 tb/tb_cond_wait_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_wait_pkg.sv
// cond_wait_pkg
// Shared types for the condition-wait engine.
//   op_e         : comparison operator applied to the watched value
//   chan_state_e : per-channel wait state
package cond_wait_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        EQ     = 3'd0,
        NE     = 3'd1,
        LT     = 3'd2,
        GT     = 3'd3,
        RANGE  = 3'd4,
        ALWAYS = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } chan_state_e;

endpackage

// File: rtl/cond_wait_chan.sv
// cond_wait_chan
// One wait channel: operand registers, comparator, FSM and, when
// COND_WAIT_TIMEOUT_EN is defined, a timeout down-counter.
//
// Ports
//   clk, rst_n     clock / async active-low reset
//   value_i        watched value
//   arm_en_i       accepted arm for this channel (already qualified by ready)
//   arm_op_i       operator code, arm_lo_i / arm_hi_i operands, arm_tmo_i timeout
//   cancel_i       abort while ARMED
//   ack_i          acknowledge while FIRED
//   idle_o, armed_o, fired_o, fire_pulse_o, timed_out_o   status
//
// state | meaning
// IDLE  | no wait pending, arm accepted
// ARMED | waiting for condition (or timeout expiry)
// FIRED | condition met, held until ack
module cond_wait_chan
    import cond_wait_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED    = 1'b0,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     value_i,
    input  logic                 arm_en_i,
    input  logic [OP_W-1:0]      arm_op_i,
    input  logic [WIDTH-1:0]     arm_lo_i,
    input  logic [WIDTH-1:0]     arm_hi_i,
    input  logic [TIMEOUT_W-1:0] arm_tmo_i,
    input  logic                 cancel_i,
    input  logic                 ack_i,
    output logic                 idle_o,
    output logic                 armed_o,
    output logic                 fired_o,
    output logic                 fire_pulse_o,
    output logic                 timed_out_o
);

    chan_state_e       state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic              pulse_q, pulse_d;
    logic              cond;
    logic              expire;
    logic              lt_lo, gt_lo, lt_hi;

    always_comb begin
        if (SIGNED) begin
            lt_lo = $signed(value_i) < $signed(lo_q);
            gt_lo = $signed(value_i) > $signed(lo_q);
            lt_hi = $signed(value_i) < $signed(hi_q);
        end else begin
            lt_lo = value_i < lo_q;
            gt_lo = value_i > lo_q;
            lt_hi = value_i < hi_q;
        end
    end

    // Empty ranges (lo >= hi) fall out naturally: no value is both > lo and < hi.
    // Illegal operator codes resolve to true so the waiter is released at once.
    always_comb begin
        cond = 1'b1;
        case (op_q)
            EQ:      cond = (value_i == lo_q);
            NE:      cond = (value_i != lo_q);
            LT:      cond = lt_lo;
            GT:      cond = gt_lo;
            RANGE:   cond = gt_lo & lt_hi;
            ALWAYS:  cond = 1'b1;
            default: cond = 1'b1;
        endcase
    end

`ifdef COND_WAIT_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 tout_q, tout_d;

    // A zero load never reaches the terminal count of 1, so it waits forever.
    assign expire      = (cnt_q == TIMEOUT_W'(1));
    assign timed_out_o = tout_q;
`else
    logic unused_tmo;
    assign unused_tmo  = ^arm_tmo_i;
    assign expire      = 1'b0;
    assign timed_out_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        pulse_d = 1'b0;
`ifdef COND_WAIT_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = tout_q;
`endif
        case (state_q)
            IDLE: begin
                if (arm_en_i) begin
                    state_d = ARMED;
                    op_d    = arm_op_i;
                    lo_d    = arm_lo_i;
                    hi_d    = arm_hi_i;
`ifdef COND_WAIT_TIMEOUT_EN
                    cnt_d   = arm_tmo_i;
                    tout_d  = 1'b0;
`endif
                end
            end
            ARMED: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else if (cond) begin
                    state_d = FIRED;
                    pulse_d = 1'b1;
                end else if (expire) begin
                    state_d = FIRED;
                    pulse_d = 1'b1;
`ifdef COND_WAIT_TIMEOUT_EN
                    tout_d  = 1'b1;
`endif
                end
`ifdef COND_WAIT_TIMEOUT_EN
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - TIMEOUT_W'(1);
                end
`endif
            end
            FIRED: begin
                if (ack_i) begin
`ifdef COND_WAIT_TIMEOUT_EN
                    tout_d = 1'b0;
`endif
                    // Re-arm in the ack cycle skips IDLE entirely.
                    if (arm_en_i) begin
                        state_d = ARMED;
                        op_d    = arm_op_i;
                        lo_d    = arm_lo_i;
                        hi_d    = arm_hi_i;
`ifdef COND_WAIT_TIMEOUT_EN
                        cnt_d   = arm_tmo_i;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef COND_WAIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end
`endif

    assign idle_o       = (state_q == IDLE);
    assign armed_o      = (state_q == ARMED);
    assign fired_o      = (state_q == FIRED);
    assign fire_pulse_o = pulse_q;

endmodule

// File: rtl/cond_wait_unit.sv
// cond_wait_unit
// Multi-channel "wait until condition" engine. Each channel compares the
// shared watched value against its armed operands and holds fired until acked.
// Optional per-channel timeout is built only when COND_WAIT_TIMEOUT_EN is defined.
//
// Ports
//   clk, rst_n                         clock / async active-low reset
//   value                              watched value
//   arm_valid/arm_ready/arm_ch/arm_op  arm handshake and target/operator
//   arm_lo, arm_hi, arm_tmo            operands and timeout load
//   cancel, ack                        per-channel abort / acknowledge
//   fired, fire_pulse, armed, timed_out  per-channel status
module cond_wait_unit
    import cond_wait_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_CH    = 4,
    parameter bit SIGNED    = 1'b0,
    parameter int TIMEOUT_W = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     value,
    input  logic                 arm_valid,
    output logic                 arm_ready,
    input  logic [CH_W-1:0]      arm_ch,
    input  logic [OP_W-1:0]      arm_op,
    input  logic [WIDTH-1:0]     arm_lo,
    input  logic [WIDTH-1:0]     arm_hi,
    input  logic [TIMEOUT_W-1:0] arm_tmo,
    input  logic [NUM_CH-1:0]    cancel,
    input  logic [NUM_CH-1:0]    ack,
    output logic [NUM_CH-1:0]    fired,
    output logic [NUM_CH-1:0]    fire_pulse,
    output logic [NUM_CH-1:0]    armed,
    output logic [NUM_CH-1:0]    timed_out
);

    logic [NUM_CH-1:0] idle;
    logic [NUM_CH-1:0] arm_en;

    // A channel out of range (non-power-of-two NUM_CH) is never ready.
    always_comb begin
        arm_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arm_ch == CH_W'(i)) begin
                arm_ready = idle[i] | (fired[i] & ack[i]);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign arm_en[g] = arm_valid & arm_ready & (arm_ch == CH_W'(g));

        cond_wait_chan #(
            .WIDTH     (WIDTH),
            .SIGNED    (SIGNED),
            .TIMEOUT_W (TIMEOUT_W)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .value_i      (value),
            .arm_en_i     (arm_en[g]),
            .arm_op_i     (arm_op),
            .arm_lo_i     (arm_lo),
            .arm_hi_i     (arm_hi),
            .arm_tmo_i    (arm_tmo),
            .cancel_i     (cancel[g]),
            .ack_i        (ack[g]),
            .idle_o       (idle[g]),
            .armed_o      (armed[g]),
            .fired_o      (fired[g]),
            .fire_pulse_o (fire_pulse[g]),
            .timed_out_o  (timed_out[g])
        );
    end

endmodule

// File: tb/tb_cond_wait_unit.sv
module tb_cond_wait_unit;
    import cond_wait_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] value;
    logic        arm_valid;
    logic        arm_ready;
    logic [1:0]  arm_ch;
    logic [2:0]  arm_op;
    logic [31:0] arm_lo;
    logic [31:0] arm_hi;
    logic [15:0] arm_tmo;
    logic [3:0]  cancel;
    logic [3:0]  ack;
    logic [3:0]  fired;
    logic [3:0]  fire_pulse;
    logic [3:0]  armed;
    logic [3:0]  timed_out;

    int errors = 0;
    int checks = 0;

    cond_wait_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .arm_valid  (arm_valid),
        .arm_ready  (arm_ready),
        .arm_ch     (arm_ch),
        .arm_op     (arm_op),
        .arm_lo     (arm_lo),
        .arm_hi     (arm_hi),
        .arm_tmo    (arm_tmo),
        .cancel     (cancel),
        .ack        (ack),
        .fired      (fired),
        .fire_pulse (fire_pulse),
        .armed      (armed),
        .timed_out  (timed_out)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input logic [1:0] ch, input logic [2:0] op,
                          input logic [31:0] lo, input logic [31:0] hi,
                          input logic [15:0] tmo);
        arm_valid = 1'b1;
        arm_ch    = ch;
        arm_op    = op;
        arm_lo    = lo;
        arm_hi    = hi;
        arm_tmo   = tmo;
        #1;
        chk("arm_ready", 32'(arm_ready), 32'h1);
        @(posedge clk);
        #1;
        arm_valid = 1'b0;
    endtask

    task automatic do_ack(input logic [3:0] m);
        ack = m;
        tick(1);
        ack = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0; value = 0; arm_valid = 0; arm_ch = 0; arm_op = 0;
        arm_lo = 0; arm_hi = 0; arm_tmo = 0; cancel = 0; ack = 0;
        tick(3);
        chk("rst_fired", 32'(fired), 32'h0);
        chk("rst_armed", 32'(armed), 32'h0);
        chk("rst_pulse", 32'(fire_pulse), 32'h0);
        chk("rst_tout",  32'(timed_out), 32'h0);
        chk("rst_ready", 32'(arm_ready), 32'h1);
        rst_n = 1'b1;
        tick(2);

        // EQ lo=2: value 0, then 1, then 2
        do_arm(2'd0, EQ, 32'd2, 32'd0, 16'd0);
        chk("eq_armed", 32'(armed), 32'h1);
        tick(99);
        value = 1;
        tick(1);
        chk("eq_no_fire_v1", 32'(fired), 32'h0);
        tick(99);
        chk("eq_no_fire_late", 32'(fired), 32'h0);
        value = 2;
        tick(1);
        chk("eq_fired", 32'(fired), 32'h1);
        chk("eq_pulse", 32'(fire_pulse), 32'h1);
        chk("eq_armed_clr", 32'(armed), 32'h0);
        tick(1);
        chk("eq_pulse_1cyc", 32'(fire_pulse), 32'h0);
        chk("eq_fired_held", 32'(fired), 32'h1);
        do_ack(4'b0001);
        chk("eq_acked", 32'(fired), 32'h0);

        // LT lo=2 with value=2, then value 0
        do_arm(2'd1, LT, 32'd2, 32'd0, 16'd0);
        tick(3);
        chk("lt_no_fire", 32'(fired), 32'h0);
        chk("lt_armed", 32'(armed), 32'h2);
        value = 0;
        tick(1);
        chk("lt_fired", 32'(fired), 32'h2);
        chk("lt_pulse", 32'(fire_pulse), 32'h2);
        // ack and re-arm in the same cycle: EQ 0 already true
        ack = 4'b0010;
        do_arm(2'd1, EQ, 32'd0, 32'd0, 16'd0);
        ack = 4'h0;
        chk("rearm_armed", 32'(armed), 32'h2);
        chk("rearm_not_fired", 32'(fired), 32'h0);
        tick(1);
        chk("level_fired", 32'(fired), 32'h2);
        chk("level_pulse", 32'(fire_pulse), 32'h2);
        do_ack(4'b0010);

        // RANGE 1<v<3
        do_arm(2'd2, RANGE, 32'd1, 32'd3, 16'd0);
        value = 0; tick(1);
        chk("rng_v0", 32'(fired), 32'h0);
        value = 1; tick(1);
        chk("rng_v1", 32'(fired), 32'h0);
        value = 3; tick(1);
        chk("rng_v3", 32'(fired), 32'h0);
        value = 2; tick(1);
        chk("rng_v2", 32'(fired), 32'h4);
        do_ack(4'b0100);
        // empty range lo=3 hi=1
        do_arm(2'd2, RANGE, 32'd3, 32'd1, 16'd0);
        for (int v = 0; v < 8; v++) begin
            value = 32'(v);
            tick(1);
            chk("rng_empty", 32'(fired), 32'h0);
        end
        cancel = 4'b0100; tick(1); cancel = 4'h0;
        chk("rng_cancelled", 32'(armed), 32'h0);

        // four channels firing on one edge
        value = 0;
        do_arm(2'd0, EQ, 32'd5, 32'd0, 16'd0);
        do_arm(2'd1, GT, 32'd4, 32'd0, 16'd0);
        do_arm(2'd2, NE, 32'd0, 32'd0, 16'd0);
        do_arm(2'd3, ALWAYS, 32'd0, 32'd0, 16'd0);
        chk("all_armed", 32'(armed), 32'hF);
        chk("all_not_fired", 32'(fired), 32'h0);
        value = 5;
        tick(1);
        chk("all_fired", 32'(fired), 32'hF);
        chk("all_pulse", 32'(fire_pulse), 32'hF);
        // re-arm ch0 without ack stalls
        arm_valid = 1'b1; arm_ch = 2'd0; arm_op = EQ; arm_lo = 32'd7; arm_hi = 0; arm_tmo = 0;
        #1;
        chk("stall_ready", 32'(arm_ready), 32'h0);
        tick(1);
        chk("stall_fired", 32'(fired), 32'hF);
        chk("stall_armed", 32'(armed), 32'h0);
        ack = 4'b0001;
        #1;
        chk("ack_ready", 32'(arm_ready), 32'h1);
        tick(1);
        arm_valid = 1'b0; ack = 4'h0;
        chk("ack_rearm_armed", 32'(armed), 32'h1);
        chk("ack_rearm_fired", 32'(fired), 32'hE);
        do_ack(4'b1110);
        chk("all_acked", 32'(fired), 32'h0);

        // cancel beats a same-cycle true condition
        do_arm(2'd1, EQ, 32'd9, 32'd0, 16'd0);
        value = 9; cancel = 4'b0010;
        tick(1);
        cancel = 4'h0;
        chk("cancel_armed", 32'(armed), 32'h1);
        chk("cancel_fired", 32'(fired), 32'h0);
        chk("cancel_pulse", 32'(fire_pulse), 32'h0);
        tick(1);
        chk("cancel_stays_idle", 32'(fired), 32'h0);
        // ack while ARMED is ignored
        do_ack(4'b0001);
        chk("ack_armed_ignored", 32'(armed), 32'h1);

        // reset while ch0 ARMED, with its condition becoming true
        value = 7; rst_n = 1'b0;
        #1;
        chk("mid_rst_armed", 32'(armed), 32'h0);
        chk("mid_rst_fired", 32'(fired), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_fired", 32'(fired), 32'h0);
        chk("post_rst_armed", 32'(armed), 32'h0);
        chk("post_rst_pulse", 32'(fire_pulse), 32'h0);

        // one-edge transient truth, then fired holds
        value = 0;
        do_arm(2'd0, EQ, 32'd3, 32'd0, 16'd0);
        value = 3; tick(1);
        value = 4; tick(1);
        chk("transient_fired", 32'(fired), 32'h1);
        do_ack(4'b0001);

        // illegal op code fires immediately, not as a timeout
        do_arm(2'd3, 3'd6, 32'd0, 32'd0, 16'd0);
        tick(1);
        chk("illegal_fired", 32'(fired), 32'h8);
        chk("illegal_tout", 32'(timed_out), 32'h0);
        do_ack(4'b1000);

`ifdef COND_WAIT_TIMEOUT_EN
        value = 0;
        do_arm(2'd0, EQ, 32'd9, 32'd0, 16'd10);
        tick(9);
        chk("tmo_not_yet", 32'(fired), 32'h0);
        tick(1);
        chk("tmo_fired", 32'(fired), 32'h1);
        chk("tmo_tout", 32'(timed_out), 32'h1);
        do_ack(4'b0001);
        chk("tmo_tout_clr", 32'(timed_out), 32'h0);
        do_arm(2'd0, EQ, 32'd9, 32'd0, 16'd3);
        tick(2);
        value = 9; tick(1);
        chk("tmo_coincide_fired", 32'(fired), 32'h1);
        chk("tmo_coincide_tout", 32'(timed_out), 32'h0);
        do_ack(4'b0001);
        value = 0;
        do_arm(2'd0, EQ, 32'd9, 32'd0, 16'd0);
        tick(30);
        chk("tmo_zero_never", 32'(fired), 32'h0);
        cancel = 4'b0001; tick(1); cancel = 4'h0;
`else
        value = 0;
        do_arm(2'd0, EQ, 32'd9, 32'd0, 16'd10);
        tick(20);
        chk("notmo_fired", 32'(fired), 32'h0);
        chk("notmo_tout", 32'(timed_out), 32'h0);
        cancel = 4'b0001; tick(1); cancel = 4'h0;
        chk("notmo_cancel", 32'(armed), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
